fifo_stream_reader: RTL and testbench
=====================================

FIFO_STREAM_READER -- requirements
Module: fifo_stream_reader

Interface
REQ-001 Parameter DATA_W, default 8, byte width of FIFO data and stream data.
REQ-002 Parameter CNT_W, default 9, width of the FIFO occupancy count.
REQ-003 Parameter PKT_LEN, default 16, bytes per output packet; legal range 1..2^CNT_W-1.
REQ-004 clk  input  1  single clock; all logic rising-edge.
REQ-005 srst  input  1  reset; synchronous and active-high.
REQ-006 fifo_dout  input  DATA_W  FIFO read data; valid one cycle after fifo_rd_en.
REQ-007 fifo_empty  input  1  FIFO empty flag.
REQ-008 fifo_data_count  input  CNT_W  FIFO occupancy in bytes.
REQ-009 fifo_rd_en  output  1  FIFO read strobe; one byte per asserted cycle.
REQ-010 m_tdata  output  DATA_W  stream data.
REQ-011 m_tvalid  output  1  stream data valid.
REQ-012 m_tready  input  1  downstream accept.
REQ-013 m_tlast  output  1  marks last byte of a packet.
REQ-014 pkt_done  output  1  one-cycle pulse on the handshake of the m_tlast byte.
REQ-015 busy  output  1  high whenever state is not IDLE.

Function
REQ-016 States: IDLE, BURST, FLUSH.
REQ-017 IDLE->BURST when fifo_data_count >= PKT_LEN; no read is issued in IDLE.
REQ-018 BURST: issue exactly PKT_LEN reads; move to FLUSH in the cycle after the PKT_LEN-th fifo_rd_en.
REQ-019 FLUSH->IDLE on the cycle m_tvalid && m_tready && m_tlast; pkt_done high in that same cycle.
REQ-020 fifo_rd_en is never asserted while fifo_empty=1; if the FIFO empties mid-BURST, reads pause and resume without loss.
REQ-021 The 2-entry output buffer accepts every FIFO read: fifo_rd_en asserts only when (buffer occupancy + reads in flight) < 2.
REQ-022 Latency: with m_tready=1, the first fifo_rd_en is in the first BURST cycle (T), and m_tvalid with byte 0 is in cycle T+2.
REQ-023 Throughput: with m_tready held 1 and FIFO non-empty, one byte per cycle is sustained after the first byte.
REQ-024 m_tvalid, once high, stays high with m_tdata/m_tlast stable until m_tready=1.
REQ-025 m_tlast = 1 only on byte index PKT_LEN-1 of each packet; PKT_LEN=1 gives m_tlast on every byte.
REQ-026 Byte order on the stream equals FIFO read order; no byte is duplicated or dropped.
REQ-027 The packet byte counter is CNT_W bits and never wraps within a packet.
REQ-028 Back-to-back packets: IDLE is occupied for at least one cycle between packets; the next start is evaluated in IDLE only.

Reset
REQ-029 On srst=1: state=IDLE, counters=0, buffer empty; fifo_rd_en=0, m_tvalid=0, m_tlast=0, pkt_done=0, busy=0, m_tdata=0.
REQ-030 srst mid-packet discards the partial packet, including bytes in flight; no output activity until a new IDLE->BURST start.
REQ-031 srst has priority over every other input in the same cycle.

Structure
REQ-032 Shared package fifo_rd_pkg holds the state enum type and the default DATA_W/CNT_W constants.
REQ-033 Sub-module fifo_rd_skid holds the 2-entry output buffer (valid/ready in, valid/ready out, DATA_W+1 bits wide to carry last).
REQ-034 The top level holds the FSM, read-credit logic and packet counter.

Verification
REQ-035 PKT_LEN=16; preload 16 bytes 0x00..0x0F; m_tready=1 -> fifo_rd_en for 16 consecutive cycles; bytes 0x00..0x0F on consecutive cycles; m_tlast on 0x0F; one pkt_done.
REQ-036 Preload 15 bytes -> no fifo_rd_en and busy=0; write a 16th byte -> packet starts, first m_tvalid 2 cycles after the first fifo_rd_en.
REQ-037 m_tready toggling 1,0,0,1 repeatedly over a 16-byte packet -> no loss or duplicate; data stable while stalled; fifo_rd_en stops when buffer plus in-flight reaches 2.
REQ-038 srst pulsed after byte 5 handshake -> all outputs 0 next cycle; reload 16 bytes -> new packet starts at the FIFO's current head with correct m_tlast.
REQ-039 Preload 48 bytes, PKT_LEN=16 -> three packets; m_tlast on bytes 15, 31 and 47; three pkt_done pulses; busy low at least one cycle between packets.
REQ-040 PKT_LEN=1 with 3 bytes preloaded -> three single-byte packets, each with m_tlast=1 and a pkt_done pulse.

Source files
------------

// File: rtl/fifo_rd_pkg.sv
// rtl/fifo_rd_pkg.sv - shared state type and default widths for the FIFO stream reader
package fifo_rd_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_CNT_W  = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/fifo_rd_skid.sv
// rtl/fifo_rd_skid.sv - two-entry output buffer between FIFO read data and the stream port
module fifo_rd_skid
    import fifo_rd_pkg::*;
#(
    parameter int W = DEF_DATA_W + 1
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         s_tvalid,
    output logic         s_tready,
    input  logic [W-1:0] s_tdata,
    output logic         m_tvalid,
    input  logic         m_tready,
    output logic [W-1:0] m_tdata
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         push;
    logic         pop;

    assign s_tready = (count != 2'd2);
    assign m_tvalid = (count != 2'd0);
    assign push     = s_tvalid && s_tready;
    assign pop      = m_tvalid && m_tready;

    // Gated so the stream reads zero whenever nothing is presented, including after reset.
    assign m_tdata  = m_tvalid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= s_tdata;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

endmodule

// File: rtl/fifo_stream_reader.sv
// rtl/fifo_stream_reader.sv - drains fixed-length packets from a FIFO onto a tvalid/tready stream
module fifo_stream_reader
    import fifo_rd_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int PKT_LEN = 16
) (
    input  logic              clk,
    input  logic              srst,
    input  logic [DATA_W-1:0] fifo_dout,
    input  logic              fifo_empty,
    input  logic [CNT_W-1:0]  fifo_data_count,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic              pkt_done,
    output logic              busy
);

    localparam logic [CNT_W-1:0] PKT_LEN_C = CNT_W'(PKT_LEN);
    localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(PKT_LEN - 1);

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  rd_cnt;
    logic [CNT_W-1:0]  rd_cnt_nxt;
    logic              in_flight;
    logic              in_flight_last;
    logic              last_rd;
    logic              skid_s_tready;
    logic [1:0]        buf_occ;
    logic              buf_pop;
    logic              credit_ok;
    logic [DATA_W:0]   buf_tdata;

    // Occupancy recovered from the buffer handshake flags: full blocks input, non-empty raises output valid.
    assign buf_occ   = {~skid_s_tready, skid_s_tready & m_tvalid};
    assign buf_pop   = m_tvalid && m_tready;

    // A byte leaving this cycle frees its slot in time for a read issued now, which keeps one byte per cycle.
    assign credit_ok = ({1'b0, buf_occ} + {2'b0, in_flight} - {2'b0, buf_pop}) < 3'd2;

    assign busy      = (state != IDLE);
    assign m_tdata   = buf_tdata[DATA_W-1:0];
    assign m_tlast   = buf_tdata[DATA_W];

    always_comb begin
        state_nxt  = state;
        rd_cnt_nxt = rd_cnt;
        fifo_rd_en = 1'b0;
        last_rd    = 1'b0;
        pkt_done   = 1'b0;
        case (state)
            IDLE: begin
                rd_cnt_nxt = '0;
                if (fifo_data_count >= PKT_LEN_C) begin
                    state_nxt = BURST;
                end
            end
            BURST: begin
                if (!fifo_empty && credit_ok) begin
                    fifo_rd_en = 1'b1;
                    rd_cnt_nxt = rd_cnt + CNT_W'(1);
                    if (rd_cnt == LAST_IDX) begin
                        last_rd   = 1'b1;
                        state_nxt = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (buf_pop && m_tlast) begin
                    pkt_done  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // No byte may leave the FIFO during reset: it would be lost with the discarded packet.
        if (srst) begin
            fifo_rd_en = 1'b0;
            last_rd    = 1'b0;
            pkt_done   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            state          <= IDLE;
            rd_cnt         <= '0;
            in_flight      <= 1'b0;
            in_flight_last <= 1'b0;
        end else begin
            state          <= state_nxt;
            rd_cnt         <= rd_cnt_nxt;
            in_flight      <= fifo_rd_en;
            in_flight_last <= last_rd;
        end
    end

    fifo_rd_skid #(
        .W (DATA_W + 1)
    ) u_skid (
        .clk      (clk),
        .srst     (srst),
        .s_tvalid (in_flight),
        .s_tready (skid_s_tready),
        .s_tdata  ({in_flight_last, fifo_dout}),
        .m_tvalid (m_tvalid),
        .m_tready (m_tready),
        .m_tdata  (buf_tdata)
    );

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb/tb_fifo_stream_reader.sv - directed scoreboard bench, PKT_LEN 16 and PKT_LEN 1 instances
module tb_fifo_stream_reader;

    logic       clk = 1'b0;
    logic       srst;
    logic [7:0] dout   [2];
    logic       empty  [2];
    logic [8:0] dcount [2];
    logic       rd_en  [2];
    logic [7:0] tdata  [2];
    logic       tvalid [2];
    logic       tready [2];
    logic       tlast  [2];
    logic       done   [2];
    logic       busy   [2];

    logic [7:0] mem    [2][256];
    logic [7:0] wr_ptr [2] = '{8'd0, 8'd0};
    logic [7:0] rd_ptr [2] = '{8'd0, 8'd0};
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];
    int         pkt_len [2] = '{16, 1};

    int checks = 0;
    int errors = 0;
    int ncyc   = 0;
    int hs_idx [2];
    int outst [2];
    int hs_cnt [2];
    int rd_cnt [2];
    int done_cnt [2];
    int first_rd [2];
    int last_rd [2];
    int first_hs [2];
    int last_hs [2];
    int max_out [2];
    logic       prev_stall [2];
    logic       prev_done [2];
    logic       prev_last [2];
    logic [7:0] prev_data [2];

    always #5 clk = ~clk;

    assign empty[0]  = (wr_ptr[0] == rd_ptr[0]);
    assign empty[1]  = (wr_ptr[1] == rd_ptr[1]);
    assign dcount[0] = {1'b0, wr_ptr[0] - rd_ptr[0]};
    assign dcount[1] = {1'b0, wr_ptr[1] - rd_ptr[1]};

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rd_en[i] && !empty[i]) begin
                dout[i]   <= mem[i][rd_ptr[i]];
                rd_ptr[i] <= rd_ptr[i] + 8'd1;
            end
        end
    end

    fifo_stream_reader #(.DATA_W(8), .CNT_W(9), .PKT_LEN(16)) dut (
        .clk(clk), .srst(srst), .fifo_dout(dout[0]), .fifo_empty(empty[0]),
        .fifo_data_count(dcount[0]), .fifo_rd_en(rd_en[0]), .m_tdata(tdata[0]),
        .m_tvalid(tvalid[0]), .m_tready(tready[0]), .m_tlast(tlast[0]),
        .pkt_done(done[0]), .busy(busy[0])
    );

    fifo_stream_reader #(.DATA_W(8), .CNT_W(9), .PKT_LEN(1)) dut_len1 (
        .clk(clk), .srst(srst), .fifo_dout(dout[1]), .fifo_empty(empty[1]),
        .fifo_data_count(dcount[1]), .fifo_rd_en(rd_en[1]), .m_tdata(tdata[1]),
        .m_tvalid(tvalid[1]), .m_tready(tready[1]), .m_tlast(tlast[1]),
        .pkt_done(done[1]), .busy(busy[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int qsize(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [7:0] qpop(input int i);
        if (i == 0) return q0.pop_front();
        return q1.pop_front();
    endfunction

    task automatic qpush(input int i, input logic [7:0] b);
        if (i == 0) q0.push_back(b);
        else q1.push_back(b);
    endtask

    task automatic push(input int i, input logic [7:0] b);
        mem[i][wr_ptr[i]] = b;
        wr_ptr[i] = wr_ptr[i] + 8'd1;
        qpush(i, b);
    endtask

    // After reset the stream must resume at whatever the FIFO model still holds.
    task automatic rebuild(input int i);
        logic [7:0] p;
        if (i == 0) q0.delete();
        else q1.delete();
        p = rd_ptr[i];
        while (p != wr_ptr[i]) begin
            qpush(i, mem[i][p]);
            p = p + 8'd1;
        end
    endtask

    task automatic clr(input int i);
        hs_cnt[i] = 0; rd_cnt[i] = 0; done_cnt[i] = 0; max_out[i] = 0;
        first_rd[i] = -1; last_rd[i] = -1; first_hs[i] = -1; last_hs[i] = -1;
    endtask

    // Called at a falling edge with inputs already driven; checks what the next rising edge will take.
    task automatic cyc();
        logic       hs;
        logic       lst;
        logic [7:0] e;
        #1;
        for (int i = 0; i < 2; i++) begin
            hs = tvalid[i] && tready[i];
            if (srst) begin
                rebuild(i);
                hs_idx[i] = 0; outst[i] = 0; prev_stall[i] = 1'b0; prev_done[i] = 1'b0;
            end else begin
                lst = hs && (hs_idx[i] == pkt_len[i] - 1);
                chk("rd_while_empty", 32'(rd_en[i] && empty[i]), 0);
                chk("pkt_done", 32'(done[i]), 32'(lst));
                if (prev_done[i]) chk("busy_gap", 32'(busy[i]), 0);
                if (prev_stall[i]) begin
                    chk("stall_valid", 32'(tvalid[i]), 1);
                    chk("stall_data", 32'(tdata[i]), 32'(prev_data[i]));
                    chk("stall_last", 32'(tlast[i]), 32'(prev_last[i]));
                end
                if (hs) begin
                    chk("sb_empty_on_hs", 32'(qsize(i) == 0), 0);
                    if (qsize(i) != 0) begin
                        e = qpop(i);
                        chk("tdata", 32'(tdata[i]), 32'(e));
                    end
                    chk("tlast", 32'(tlast[i]), 32'(lst));
                    hs_idx[i] = lst ? 0 : hs_idx[i] + 1;
                    if (hs_cnt[i] == 0) first_hs[i] = ncyc;
                    last_hs[i] = ncyc;
                    hs_cnt[i]++;
                end
                if (rd_en[i]) begin
                    chk("read_credit", 32'((outst[i] - int'(hs)) < 2), 1);
                    if (rd_cnt[i] == 0) first_rd[i] = ncyc;
                    last_rd[i] = ncyc;
                    rd_cnt[i]++;
                end
                outst[i] = outst[i] + int'(rd_en[i]) - int'(hs);
                if (outst[i] > max_out[i]) max_out[i] = outst[i];
                if (done[i]) done_cnt[i]++;
                prev_stall[i] = tvalid[i] && !tready[i];
                prev_data[i]  = tdata[i];
                prev_last[i]  = tlast[i];
                prev_done[i]  = done[i];
            end
        end
        ncyc++;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_until(input int i, input int ndone, input int budget);
        int n;
        n = 0;
        while (done_cnt[i] < ndone && n < budget) begin
            cyc();
            n++;
        end
        chk("done_timeout", 32'(done_cnt[i] >= ndone), 1);
    endtask

    initial begin
        srst = 1'b1;
        tready[0] = 1'b1;
        tready[1] = 1'b1;
        clr(0);
        clr(1);
        @(negedge clk);
        cyc();
        cyc();
        chk("rst_rd_en", 32'(rd_en[0]), 0);
        chk("rst_tvalid", 32'(tvalid[0]), 0);
        chk("rst_tlast", 32'(tlast[0]), 0);
        chk("rst_pkt_done", 32'(done[0]), 0);
        chk("rst_busy", 32'(busy[0]), 0);
        chk("rst_tdata", 32'(tdata[0]), 0);
        chk("rst_busy_len1", 32'(busy[1]), 0);
        srst = 1'b0;

        // 15 bytes is below one packet: no reads, stays idle.
        for (int b = 0; b < 15; b++) push(0, 8'(b));
        for (int k = 0; k < 8; k++) begin
            cyc();
            chk("idle_no_read", 32'(rd_en[0]), 0);
            chk("idle_busy", 32'(busy[0]), 0);
        end
        clr(0);
        push(0, 8'h0F);
        run_until(0, 1, 80);
        chk("p1_reads", 32'(rd_cnt[0]), 16);
        chk("p1_reads_contig", 32'(last_rd[0] - first_rd[0] + 1), 16);
        chk("p1_bytes", 32'(hs_cnt[0]), 16);
        chk("p1_bytes_contig", 32'(last_hs[0] - first_hs[0] + 1), 16);
        chk("p1_latency", 32'(first_hs[0] - first_rd[0]), 2);
        chk("p1_done_count", 32'(done_cnt[0]), 1);
        cyc();

        // Downstream stalls 1,0,0,1.
        clr(0);
        for (int b = 0; b < 16; b++) push(0, 8'(8'h20 + b));
        for (int k = 0; k < 300 && done_cnt[0] < 1; k++) begin
            tready[0] = (k % 4 == 0) || (k % 4 == 3);
            cyc();
        end
        tready[0] = 1'b1;
        chk("stall_done", 32'(done_cnt[0]), 1);
        chk("stall_bytes", 32'(hs_cnt[0]), 16);
        chk("stall_reads", 32'(rd_cnt[0]), 16);
        chk("stall_max_outstanding", 32'(max_out[0]), 2);
        cyc();

        // Three back-to-back packets.
        clr(0);
        for (int b = 0; b < 48; b++) push(0, 8'(8'h40 + b));
        run_until(0, 3, 200);
        chk("b2b_bytes", 32'(hs_cnt[0]), 48);
        chk("b2b_reads", 32'(rd_cnt[0]), 48);
        chk("b2b_done_count", 32'(done_cnt[0]), 3);
        cyc();

        // Reset after byte 5 of a packet, then resume from the FIFO head.
        clr(0);
        for (int b = 0; b < 16; b++) push(0, 8'(8'h80 + b));
        for (int k = 0; k < 100 && hs_cnt[0] < 6; k++) cyc();
        chk("mid_reset_reach", 32'(hs_cnt[0]), 6);
        srst = 1'b1;
        tready[0] = 1'b0;
        cyc();
        srst = 1'b0;
        tready[0] = 1'b1;
        #1;
        chk("post_rst_rd_en", 32'(rd_en[0]), 0);
        chk("post_rst_tvalid", 32'(tvalid[0]), 0);
        chk("post_rst_tlast", 32'(tlast[0]), 0);
        chk("post_rst_done", 32'(done[0]), 0);
        chk("post_rst_busy", 32'(busy[0]), 0);
        chk("post_rst_tdata", 32'(tdata[0]), 0);
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("post_rst_quiet", 32'(tvalid[0] || rd_en[0]), 0);
        end
        clr(0);
        for (int b = 0; b < 16; b++) push(0, 8'(8'h90 + b));
        run_until(0, 1, 100);
        chk("resume_bytes", 32'(hs_cnt[0]), 16);
        chk("resume_done_count", 32'(done_cnt[0]), 1);
        cyc();

        // PKT_LEN = 1: every byte is its own packet.
        clr(1);
        push(1, 8'hA1);
        push(1, 8'hA2);
        push(1, 8'hA3);
        run_until(1, 3, 60);
        chk("len1_bytes", 32'(hs_cnt[1]), 3);
        chk("len1_reads", 32'(rd_cnt[1]), 3);
        chk("len1_done_count", 32'(done_cnt[1]), 3);
        cyc();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
